note_recorder: RTL

- Record-side counterpart of the playback path. Samples the free-play note code (`ascii`) and compresses it into (note, duration) events.
- Writes the events into one of two track regions (A/B) of the shared recording RAM.
- Publishes each track's event count so the playback logic knows how many words to read.

---
 rtl/note_recorder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/note_recorder.sv
// Compresses the free-play note stream into (note, duration) events in track A/B of the recording RAM.
// Writes land one cycle after the note change; no backpressure. Option: NOTE_RECORDER_TERMINATOR_EN.
module note_recorder #(
  parameter int ADDR_W   = 8,
  parameter int DUR_W    = 12,
  parameter int TICK_DIV = 500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           ascii,
  input  logic                 rec_start,
  input  logic                 rec_stop,
  input  logic                 track_sel,
  output logic                 ram_we,
  output logic [ADDR_W:0]      ram_addr,
  output logic [6+DUR_W:0]     ram_wdata,
  output logic                 recording,
  output logic                 full,
  output logic [ADDR_W:0]      len_a,
  output logic [ADDR_W:0]      len_b
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, TERM} state_t;

  state_t              state, state_nx;
  logic                trk, trk_nx;
  logic [ADDR_W:0]     idx, idx_nx;
  logic [6:0]          cur_note, note_nx;
  logic [DUR_W-1:0]    dur, dur_nx;
  logic [PW-1:0]       presc, presc_nx;
  logic                full_nx;
  logic [ADDR_W:0]     len_a_nx, len_b_nx;
  logic                tick;
  logic                wr_en, wr_event, commit;
  logic [6+DUR_W:0]    wr_dat;

  always_comb begin
    state_nx = state;
    trk_nx   = trk;
    idx_nx   = idx;
    note_nx  = cur_note;
    dur_nx   = dur;
    presc_nx = presc;
    full_nx  = full;
    len_a_nx = len_a;
    len_b_nx = len_b;
    wr_en    = 1'b0;
    wr_event = 1'b0;
    commit   = 1'b0;
    wr_dat   = {cur_note, dur};
    tick     = (presc == TICK_LAST);

    case (state)
      IDLE: begin
        if (rec_start) begin
          trk_nx   = track_sel;
          idx_nx   = '0;
          note_nx  = ascii;
          dur_nx   = '0;
          presc_nx = '0;
          full_nx  = 1'b0;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (rec_stop) begin
          state_nx = FLUSH;
        end else if (ascii != cur_note) begin
          note_nx = ascii;
          if (dur != '0) begin
            wr_en    = 1'b1;
            wr_event = 1'b1;
            dur_nx   = '0;
            presc_nx = '0;
          end else begin
            // Sub-tick glitch: the old note is absorbed, timing carries on.
            presc_nx = tick ? '0 : presc + 1'b1;
            if (tick) dur_nx = DUR_W'(1);
          end
        end else begin
          presc_nx = tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (dur == '1) begin
              wr_en    = 1'b1;
              wr_event = 1'b1;
              dur_nx   = '0;
            end else begin
              dur_nx = dur + 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (dur != '0) begin
          wr_en    = 1'b1;
          wr_event = 1'b1;
        end
        dur_nx = '0;
        commit = 1'b1;
`ifdef NOTE_RECORDER_TERMINATOR_EN
        state_nx = TERM;
`else
        state_nx = IDLE;
`endif
      end
      TERM: begin
        wr_en    = 1'b1;
        wr_dat   = '1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (wr_en) idx_nx = idx + 1'b1;

    // Filling the last slot ends the take at once; idx_nx is then 2^ADDR_W.
    if (wr_event && (idx[ADDR_W-1:0] == {ADDR_W{1'b1}})) begin
      full_nx  = 1'b1;
      commit   = 1'b1;
      state_nx = IDLE;
    end

    if (commit) begin
      if (trk) len_b_nx = idx_nx;
      else     len_a_nx = idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      trk       <= 1'b0;
      idx       <= '0;
      cur_note  <= '0;
      dur       <= '0;
      presc     <= '0;
      full      <= 1'b0;
      len_a     <= '0;
      len_b     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      recording <= 1'b0;
    end else begin
      state     <= state_nx;
      trk       <= trk_nx;
      idx       <= idx_nx;
      cur_note  <= note_nx;
      dur       <= dur_nx;
      presc     <= presc_nx;
      full      <= full_nx;
      len_a     <= len_a_nx;
      len_b     <= len_b_nx;
      ram_we    <= wr_en;
      recording <= (state_nx != IDLE);
      if (wr_en) begin
        ram_addr  <= {trk, idx[ADDR_W-1:0]};
        ram_wdata <= wr_dat;
      end
    end
  end

endmodule
